// File: rtl/pattern_scan_ctrl.sv
// Programmable serial pattern scanner: loads pattern/length/overlap/frame config,
// then scans one frame of valid-qualified bits, counting Mealy matches.
module pattern_scan_ctrl #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned LENW   = 4,
    parameter int unsigned FW     = 16,
    parameter int unsigned CW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LENW-1:0]   cfg_len,
    input  logic              cfg_ovl,
    input  logic [FW-1:0]     cfg_frame,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              busy,
    output logic              match,
    output logic [CW-1:0]     match_count,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e              state_q, state_d;
    logic [MAXLEN-1:0]   pat_q, pat_d;
    logic [LENW-1:0]     len_q, len_d;
    logic                ovl_q, ovl_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic [MAXLEN-2:0]   hist_q, hist_d;
    logic [LENW-1:0]     fill_q, fill_d;
    logic [FW-1:0]       rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [MAXLEN-1:0]   win;
    logic [MAXLEN-1:0]   mask;
    logic                hit_c;
    logic                len_ok;

    // Window compare: only the low len bits count, and only once enough history exists.
    always_comb begin
        win = {hist_q, in_bit};
        for (int unsigned i = 0; i < MAXLEN; i++) begin
            mask[i] = (i < 32'(len_q));
        end
        hit_c = (((win ^ pat_q) & mask) == '0) && (fill_q >= (len_q - LENW'(1)));
    end

    assign len_ok      = (cfg_len != '0) && (cfg_len <= LENW'(MAXLEN));
    assign match       = (state_q == SCAN) && in_valid && !abort && hit_c;
    assign busy        = (state_q == SCAN);
    assign done        = (state_q == DONE);
    assign match_count = cnt_q;
    assign cfg_err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= LENW'(1);
            ovl_q   <= 1'b1;
            frame_q <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            frame_q <= frame_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        frame_d = frame_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // A config write shadows a simultaneous start.
                if (cfg_wr) begin
                    if (len_ok) begin
                        pat_d   = cfg_pattern;
                        len_d   = cfg_len;
                        ovl_d   = cfg_ovl;
                        frame_d = cfg_frame;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (start) begin
                    if (frame_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = SCAN;
                        rem_d   = frame_q;
                        cnt_d   = '0;
                        hist_d  = '0;
                        fill_d  = '0;
                    end
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    rem_d = rem_q - FW'(1);
                    if (match && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (match && !ovl_q) begin
                        hist_d = '0;
                        fill_d = '0;
                    end else begin
                        hist_d = win[MAXLEN-2:0];
                        if (fill_q != LENW'(MAXLEN)) begin
                            fill_d = fill_q + LENW'(1);
                        end
                    end
                    if (rem_q == FW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed self-checking bench for pattern_scan_ctrl.
module tb_pattern_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_ovl;
    logic [15:0] cfg_frame;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic        in_bit;
    logic        busy;
    logic        match;
    logic [7:0]  match_count;
    logic        done;
    logic        cfg_err;

    int tests = 0;
    int fails = 0;

    pattern_scan_ctrl #(.MAXLEN(8), .LENW(4), .FW(16), .CW(8)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cfg_frame(cfg_frame),
        .start(start), .abort(abort), .in_valid(in_valid), .in_bit(in_bit),
        .busy(busy), .match(match), .match_count(match_count),
        .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                       input logic [15:0] f, input logic exp_err);
        cfg_wr = 1'b1; cfg_pattern = p; cfg_len = l; cfg_ovl = o; cfg_frame = f;
        tick();
        cfg_wr = 1'b0;
        check("cfg_err_after_wr", 32'(cfg_err), 32'(exp_err));
    endtask

    task automatic do_start(input logic exp_err);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_err", 32'(cfg_err), 32'(exp_err));
        check("start_busy", 32'(busy), 32'(!exp_err));
        if (!exp_err) check("start_cnt_clear", 32'(match_count), 32'(0));
    endtask

    task automatic send_bit(input logic b, input logic exp_m);
        in_valid = 1'b1; in_bit = b;
        #1;
        check("match", 32'(match), 32'(exp_m));
        tick();
        in_valid = 1'b0; in_bit = 1'b0;
    endtask

    task automatic gap_cycle();
        in_valid = 1'b0; in_bit = 1'b1;
        #1;
        check("match_gap", 32'(match), 32'(0));
        tick();
        in_bit = 1'b0;
    endtask

    task automatic run_stream(input logic [15:0] s, input int n, input logic [15:0] m);
        for (int i = 0; i < n; i++) send_bit(s[i], m[i]);
    endtask

    task automatic check_end(input logic [7:0] exp_cnt);
        check("done_pulse", 32'(done), 32'(1));
        check("busy_in_done", 32'(busy), 32'(0));
        check("final_cnt", 32'(match_count), 32'(exp_cnt));
        tick();
        check("done_low", 32'(done), 32'(0));
        check("busy_idle", 32'(busy), 32'(0));
        check("cnt_hold", 32'(match_count), 32'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1; cfg_wr = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_ovl = 1'b0;
        cfg_frame = '0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_match", 32'(match), 32'(0));
        check("rst_cnt", 32'(match_count), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(cfg_err), 32'(0));
        // Reset frame is 0, so start must be rejected.
        do_start(1'b1);

        // bbcbc overlapping, matches on bits 5 and 10.
        cfg(8'b00101, 4'd5, 1'b1, 16'd10, 1'b0);
        do_start(1'b0);
        run_stream(16'h0294, 10, 16'h0210);
        check_end(8'd2);

        // 101 overlapping vs non-overlapping.
        cfg(8'b101, 4'd3, 1'b1, 16'd5, 1'b0);
        do_start(1'b0);
        run_stream(16'h0015, 5, 16'h0014);
        check_end(8'd2);
        cfg(8'b101, 4'd3, 1'b0, 16'd5, 1'b0);
        do_start(1'b0);
        run_stream(16'h0015, 5, 16'h0004);
        check_end(8'd1);

        // Illegal lengths rejected; previous non-overlap config must survive.
        cfg(8'hFF, 4'd0, 1'b1, 16'd7, 1'b1);
        tick();
        check("err_one_cycle", 32'(cfg_err), 32'(0));
        cfg(8'hFF, 4'd9, 1'b1, 16'd7, 1'b1);
        do_start(1'b0);
        run_stream(16'h0015, 5, 16'h0004);
        check_end(8'd1);
        cfg(8'b101, 4'd3, 1'b0, 16'd0, 1'b0);
        do_start(1'b1);
        tick();
        check("frame0_idle", 32'(busy), 32'(0));

        // Start alongside cfg_wr is ignored.
        cfg_wr = 1'b1; start = 1'b1; cfg_pattern = 8'b00101; cfg_len = 4'd5;
        cfg_ovl = 1'b1; cfg_frame = 16'd10;
        tick();
        cfg_wr = 1'b0; start = 1'b0;
        check("wr_beats_start", 32'(busy), 32'(0));

        // Sparse valid: every third cycle.
        do_start(1'b0);
        for (int i = 0; i < 10; i++) begin
            gap_cycle();
            gap_cycle();
            send_bit(16'h0294 >> i & 16'h1 ? 1'b1 : 1'b0, (i == 4) || (i == 9));
        end
        check_end(8'd2);

        // Abort with a would-be match; cfg_wr during SCAN ignored.
        cfg(8'b101, 4'd3, 1'b1, 16'd10, 1'b0);
        do_start(1'b0);
        run_stream(16'h0005, 4, 16'h0004);
        cfg_wr = 1'b1; cfg_pattern = 8'b111; cfg_len = 4'd3; cfg_frame = 16'd3;
        tick();
        cfg_wr = 1'b0;
        abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        #1;
        check("abort_match", 32'(match), 32'(0));
        tick();
        abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_cnt", 32'(match_count), 32'(1));
        tick();
        check("abort_no_done", 32'(done), 32'(0));
        do_start(1'b0);
        run_stream(16'h0005, 3, 16'h0004);
        check("readback_busy", 32'(busy), 32'(1));
        check("readback_cnt", 32'(match_count), 32'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Saturation with len=1 all-ones stream.
        cfg(8'b1, 4'd1, 1'b1, 16'd300, 1'b0);
        do_start(1'b0);
        for (int i = 0; i < 300; i++) send_bit(1'b1, 1'b1);
        check_end(8'd255);

        // Reset mid-scan restores defaults.
        do_start(1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
        check("pre_rst_cnt", 32'(match_count), 32'(10));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_cnt", 32'(match_count), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        do_start(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Programmable controller for the team's serial pattern-detector datapath. Bit encoding is b=0, c=1.
- Loads a pattern, length, overlap mode and frame length, then scans one frame of the serial stream under a valid handshake.
- Emits a Mealy match pulse per detection, a match counter and a done pulse.
- Replaces hard-wired per-pattern FSMs with one configurable sequencer.

Parameters:
- MAXLEN, 8, maximum pattern length in bits.
- LENW, 4, width of cfg_len; must hold MAXLEN.
- FW, 16, width of cfg_frame (bits per scan).
- CW, 8, width of match_count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_wr  in  1  config write strobe; honoured in IDLE only.
- cfg_pattern  in  MAXLEN  pattern. Bit [cfg_len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LENW  pattern length; legal range 1..MAXLEN.
- cfg_ovl  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_frame  in  FW  number of valid bits to scan per run.
- start  in  1  begin a scan; honoured in IDLE only.
- abort  in  1  terminate the scan.
- in_valid  in  1  in_bit is consumed this cycle.
- in_bit  in  1  serial data bit.
- busy  out  1  high in SCAN.
- match  out  1  Mealy detect pulse, combinational from in_valid/in_bit.
- match_count  out  CW  matches in the current/last run.
- done  out  1  one-cycle pulse at end of frame.
- cfg_err  out  1  one-cycle pulse on a rejected cfg_wr or start.

Behaviour:
- Reset: everything is synchronous on the clk edge.
  - State goes to IDLE; history and fill counter clear.
  - Outputs: busy=0, match=0, match_count=0, done=0, cfg_err=0.
  - Config registers: pattern=0, len=1, ovl=1, frame=0.
- States are IDLE, SCAN, DONE.
- IDLE, cfg_wr:
  - cfg_len in 1..MAXLEN: all config registers load next cycle.
  - Otherwise: registers unchanged and cfg_err pulses next cycle.
  - cfg_wr outside IDLE is ignored silently.
- IDLE, start:
  - frame==0: stay in IDLE and pulse cfg_err.
  - Otherwise: go to SCAN, set remaining=frame, clear match_count, history and fill.
  - cfg_wr and start in the same cycle: cfg_wr loads, start is ignored.
- SCAN, bit consumption:
  - Each in_valid cycle consumes in_bit; cycles without in_valid change nothing.
  - Window w = {history, in_bit}, low len bits. history holds the prior bits, newest at LSB.
  - match = in_valid & (fill >= len-1) & (w[len-1:0] == pattern[len-1:0]). fill saturates at MAXLEN.
  - The match decision is made in the same cycle the bit is presented, so latency is 0.
- SCAN, on a match:
  - match_count increments and saturates at 2^CW-1.
  - ovl=1: history shifts in in_bit; fill increments.
  - ovl=0: history and fill clear, so the next match needs len fresh bits.
- SCAN, frame end and abort:
  - remaining decrements per consumed bit.
  - Consuming the last bit (remaining==1) goes to DONE; a match on that last bit is still counted.
  - abort has priority over in_valid in the same cycle: go to IDLE, no done pulse, bit not consumed, match forced to 0, match_count holds its value.
- DONE: done=1 for exactly one cycle, then IDLE. match_count holds until the next start.
- busy=1 only in SCAN; match=0 outside SCAN.
- Config is frozen during SCAN and DONE.
- Reset mid-SCAN returns to the reset state above.

Test Plan:
- Config pattern=5'b00101 (bbcbc), len=5, ovl=1, frame=10; stream 0,0,1,0,1,0,0,1,0,1 → match pulses on bits 5 and 10, match_count=2, done 1 cycle after bit 10, busy low after done.
- Pattern=3'b101, len=3, frame=5, stream 1,0,1,0,1: ovl=1 gives matches at bits 3 and 5, count=2; ovl=0 gives a match at bit 3 only, count=1.
- cfg_wr with cfg_len=0, then again with cfg_len=9 (MAXLEN=8) → cfg_err pulses each time and the previous config is retained. start with frame=0 → cfg_err, stays in IDLE.
- Gaps in in_valid (valid every 3rd cycle) with the bbcbc stream → same match positions and count as the first test; match never asserts when in_valid=0.
- abort asserted with in_valid=1 after the 4th bit of a 10-bit frame → IDLE next cycle, no done, count frozen. A cfg_wr during SCAN is ignored (verify by a readback run).
- Pattern=1'b1, len=1, frame=300, all-ones stream with CW=8 → match_count saturates at 255. rst mid-scan → busy=0 and match_count=0 next cycle.
